// File: rtl/disp_pkg.sv
// Shared types and constants for the multiplexed 7-segment display scanner.
// Segment patterns are {g,f,e,d,c,b,a}, active-low.
package disp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ON    = 2'd1,
    ST_BLANK = 2'd2
  } state_e;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [6:0] GLYPH_0 = 7'h40;
  localparam logic [6:0] GLYPH_1 = 7'h79;
  localparam logic [6:0] GLYPH_2 = 7'h24;
  localparam logic [6:0] GLYPH_3 = 7'h30;
  localparam logic [6:0] GLYPH_4 = 7'h19;
  localparam logic [6:0] GLYPH_5 = 7'h12;
  localparam logic [6:0] GLYPH_6 = 7'h02;
  localparam logic [6:0] GLYPH_7 = 7'h78;
  localparam logic [6:0] GLYPH_8 = 7'h00;
  localparam logic [6:0] GLYPH_9 = 7'h10;

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD to active-low 7-segment decoder.
// Codes A-F are shown blank.
module bcd_to_7seg
  import disp_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg_n
);

  always_comb begin
    seg_n = SEG_BLANK;
    case (bcd)
      4'd0: seg_n = GLYPH_0;
      4'd1: seg_n = GLYPH_1;
      4'd2: seg_n = GLYPH_2;
      4'd3: seg_n = GLYPH_3;
      4'd4: seg_n = GLYPH_4;
      4'd5: seg_n = GLYPH_5;
      4'd6: seg_n = GLYPH_6;
      4'd7: seg_n = GLYPH_7;
      4'd8: seg_n = GLYPH_8;
      4'd9: seg_n = GLYPH_9;
      default: seg_n = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/display_scan_ctrl.sv
// Digit-scan scheduler for the clock/alarm 7-segment display.
// Define SCAN_PWM_EN to gate segments by the bright input.
module display_scan_ctrl
  import disp_pkg::*;
#(
  parameter int N_DIGITS  = 8,
  parameter int IDX_W     = 3,
  parameter int ON_CYC    = 4,
  parameter int BLANK_CYC = 1
)(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic [N_DIGITS-1:0]   digit_mask,
  input  logic [4*N_DIGITS-1:0] bcd_in,
  input  logic [3:0]            bright,
  output logic [N_DIGITS-1:0]   an_n,
  output logic [6:0]            seg_n,
  output logic [IDX_W-1:0]      dig_idx,
  output logic                  frame_done
);

  localparam int CMAX  = (ON_CYC > BLANK_CYC) ? ON_CYC : BLANK_CYC;
  localparam int CNT_W = (CMAX > 1) ? $clog2(CMAX) : 1;

  function automatic logic has_above(
    input logic [N_DIGITS-1:0] m,
    input logic [IDX_W-1:0]    cur
  );
    logic hit;
    hit = 1'b0;
    for (int j = 0; j < N_DIGITS; j++)
      if (m[j] && j > int'(cur)) hit = 1'b1;
    return hit;
  endfunction

  function automatic logic [IDX_W-1:0] low_idx(
    input logic [N_DIGITS-1:0] m
  );
    logic [IDX_W-1:0] r;
    r = '0;
    for (int j = N_DIGITS - 1; j >= 0; j--)
      if (m[j]) r = IDX_W'(j);
    return r;
  endfunction

  // First set bit above cur, else wrap to the lowest set bit.
  function automatic logic [IDX_W-1:0] next_idx(
    input logic [N_DIGITS-1:0] m,
    input logic [IDX_W-1:0]    cur
  );
    logic [IDX_W-1:0] above;
    logic             hit;
    above = '0;
    hit   = 1'b0;
    for (int j = N_DIGITS - 1; j >= 0; j--)
      if (m[j] && j > int'(cur)) begin
        above = IDX_W'(j);
        hit   = 1'b1;
      end
    return hit ? above : low_idx(m);
  endfunction

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [N_DIGITS-1:0]  mask_q, mask_d;
  logic [N_DIGITS-1:0]  an_q, an_d;
  logic [6:0]           seg_q, seg_d;
  logic                 fd_q, fd_d;
  logic                 enter_on;
  logic                 lit;
  logic [3:0]           bcd_sel;
  logic [6:0]           glyph;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    mask_d   = mask_q;
    fd_d     = 1'b0;
    enter_on = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (en && |digit_mask) begin
          state_d  = ST_ON;
          idx_d    = low_idx(digit_mask);
          enter_on = 1'b1;
        end
      end
      ST_ON: begin
        if (cnt_q == CNT_W'(ON_CYC - 1)) begin
          state_d = ST_BLANK;
          cnt_d   = '0;
          fd_d    = !has_above(mask_q, idx_q);
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_BLANK: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(BLANK_CYC - 1)) begin
          cnt_d = '0;
          if (en && |digit_mask) begin
            state_d  = ST_ON;
            idx_d    = next_idx(digit_mask, idx_q);
            enter_on = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
    // Frame end is judged against the mask this visit started with.
    if (enter_on) mask_d = digit_mask;
  end

  assign bcd_sel = bcd_in[{idx_d, 2'b00} +: 4];

  bcd_to_7seg u_dec (
    .bcd   (bcd_sel),
    .seg_n (glyph)
  );

`ifdef SCAN_PWM_EN
  logic [3:0] bright_q, bright_d;

  function automatic int pwm_win(input logic [3:0] b);
    return ((int'(b) + 1) * ON_CYC) >> 4;
  endfunction

  assign bright_d = enter_on ? bright : bright_q;
  assign lit      = int'(cnt_d) < pwm_win(bright_d);

  always_ff @(posedge clk) begin
    if (reset) bright_q <= '0;
    else       bright_q <= bright_d;
  end
`else
  logic unused_bright;
  assign unused_bright = ^bright;
  assign lit           = 1'b1;
`endif

  always_comb begin
    an_d  = '1;
    seg_d = SEG_BLANK;
    if (state_d == ST_ON) begin
      an_d[idx_d] = 1'b0;
      if (lit) seg_d = glyph;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      mask_q  <= '0;
      an_q    <= '1;
      seg_q   <= SEG_BLANK;
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      mask_q  <= mask_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      fd_q    <= fd_d;
    end
  end

  assign an_n       = an_q;
  assign seg_n      = seg_q;
  assign dig_idx    = idx_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Randomised self-checking bench for display_scan_ctrl against a visit-timeline model.
// Build with SCAN_PWM_EN defined to exercise the brightness window.
module tb_display_scan_ctrl;

  localparam int N  = 8;
  localparam int ON = 4;
  localparam int BL = 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          en;
  logic [N-1:0]  digit_mask;
  logic [4*N-1:0] bcd_in;
  logic [3:0]    bright;
  logic [N-1:0]  an_n;
  logic [6:0]    seg_n;
  logic [2:0]    dig_idx;
  logic          frame_done;

  display_scan_ctrl #(
    .N_DIGITS (N),
    .IDX_W    (3),
    .ON_CYC   (ON),
    .BLANK_CYC(BL)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .digit_mask(digit_mask),
    .bcd_in    (bcd_in),
    .bright    (bright),
    .an_n      (an_n),
    .seg_n     (seg_n),
    .dig_idx   (dig_idx),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  bit chk_on = 1'b0;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  // Standard active-high segment table, inverted for the active-low pins.
  function automatic logic [6:0] glyph(input logic [3:0] v);
    logic [6:0] hi;
    case (v)
      4'd0: hi = 7'h3F;
      4'd1: hi = 7'h06;
      4'd2: hi = 7'h5B;
      4'd3: hi = 7'h4F;
      4'd4: hi = 7'h66;
      4'd5: hi = 7'h6D;
      4'd6: hi = 7'h7D;
      4'd7: hi = 7'h07;
      4'd8: hi = 7'h7F;
      4'd9: hi = 7'h6F;
      default: hi = 7'h00;
    endcase
    return ~hi;
  endfunction

  function automatic int m_next(input logic [N-1:0] m, input int cur);
    for (int k = 1; k <= N; k++)
      if (m[(cur + k) % N]) return (cur + k) % N;
    return cur;
  endfunction

  function automatic bit m_last(input logic [N-1:0] m, input int cur);
    for (int j = cur + 1; j < N; j++)
      if (m[j]) return 1'b0;
    return 1'b1;
  endfunction

  // Model: a visit is ON cycles lit then BL cycles dark; pos counts within it.
  bit         busy;
  int         pos;
  int         midx;
  logic [N-1:0] mmask;
  logic [3:0] mbright;
  logic [N-1:0] e_an;
  logic [6:0] e_seg;
  logic [2:0] e_idx;
  logic       e_fd;

  always @(posedge clk) begin : model
    bit go;
    int win;
    go = 1'b0;
    if (reset) begin
      busy = 1'b0;
      pos  = 0;
      midx = 0;
      e_fd = 1'b0;
    end else begin
      e_fd = 1'b0;
      if (busy) begin
        pos++;
        if (pos == ON) e_fd = m_last(mmask, midx);
        if (pos == ON + BL) begin
          busy = 1'b0;
          if (en && digit_mask != 0) begin
            midx = m_next(digit_mask, midx);
            go   = 1'b1;
          end
        end
      end else if (en && digit_mask != 0) begin
        midx = m_next(digit_mask, N - 1);
        go   = 1'b1;
      end
      if (go) begin
        busy    = 1'b1;
        pos     = 0;
        mmask   = digit_mask;
        mbright = bright;
      end
    end
`ifdef SCAN_PWM_EN
    win = ((int'(mbright) + 1) * ON) >> 4;
`else
    win = ON;
`endif
    if (busy && pos < ON) begin
      e_an  = ~(N'(1) << midx);
      e_seg = (pos < win) ? glyph(bcd_in[4*midx +: 4]) : 7'h7F;
    end else begin
      e_an  = '1;
      e_seg = 7'h7F;
    end
    e_idx = 3'(midx);
  end

  always @(negedge clk) begin
    if (chk_on) begin
      check("an_n", an_n, e_an);
      check("seg_n", seg_n, e_seg);
      check("dig_idx", dig_idx, e_idx);
      check("frame_done", frame_done, e_fd);
    end
  end

  task automatic wait_an(input logic [N-1:0] v, input string nm);
    int k = 0;
    while (an_n !== v && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (an_n !== v) begin
      tests++;
      fails++;
      $display("FAIL %s timeout: an_n %0h, required %0h", nm, an_n, v);
    end
  endtask

  task automatic wait_lit(input string nm);
    int k = 0;
    while (an_n === '1 && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (an_n === '1) begin
      tests++;
      fails++;
      $display("FAIL %s timeout: an_n %0h, required a digit", nm, an_n);
    end
  endtask

  task automatic on_span(input logic [N-1:0] v, output int n, output int l);
    n = 0;
    l = 0;
    while (an_n === v && n < 20) begin
      n++;
      if (seg_n !== 7'h7F) l++;
      @(negedge clk);
    end
  endtask

  int n_on, n_lit, k;

  initial begin
    reset      = 1'b1;
    en         = 1'b0;
    digit_mask = '0;
    bcd_in     = 32'h7654_3210;
    bright     = 4'hF;
    repeat (3) @(negedge clk);
    check("rst_an", an_n, 8'hFF);
    check("rst_seg", seg_n, 7'h7F);
    check("rst_idx", dig_idx, 3'd0);
    check("rst_fd", frame_done, 1'b0);
    chk_on     = 1'b1;
    reset      = 1'b0;
    en         = 1'b1;
    digit_mask = 8'hFF;

    // Full scan: frame ends after digit 7, then wraps to 0.
    k = 0;
    while (frame_done !== 1'b1 && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("t1_fd_seen", frame_done, 1'b1);
    check("t1_fd_idx", dig_idx, 3'd7);
    check("t1_fd_blank", an_n, 8'hFF);
    @(negedge clk);
    check("t1_wrap_an", an_n, 8'hFE);
    check("t1_wrap_seg", seg_n, 7'h40);
    on_span(8'hFE, n_on, n_lit);
    check("t1_on_len", n_on, ON);
    check("t1_blank", an_n, 8'hFF);
    @(negedge clk);
    check("t1_next", an_n, 8'hFD);

    // Sparse mask: digits 2 and 5 alternate.
    digit_mask = 8'b0010_0100;
    wait_an(8'hFB, "t2_d2");
    check("t2_seg2", seg_n, 7'h24);
    wait_an(8'hDF, "t2_d5");
    check("t2_seg5", seg_n, 7'h12);
    wait_lit("t2_gap");
    wait_an(8'hFF, "t2_off");
    wait_lit("t2_back");
    check("t2_back_an", an_n, 8'hFB);

    // Mask shrinks mid-ON of digit 3: it completes, then digit 0.
    digit_mask = 8'hFF;
    wait_an(8'hF7, "t3_d3");
    @(negedge clk);
    digit_mask = 8'h01;
    on_span(8'hF7, n_on, n_lit);
    check("t3_on_len", n_on + 1, ON);
    wait_lit("t3_resume");
    check("t3_next", an_n, 8'hFE);

    // en and mask drops finish the visit and go dark.
    digit_mask = 8'hFF;
    wait_an(8'hFD, "t4_d1");
    en = 1'b0;
    repeat (12) @(negedge clk);
    check("t4_en_an", an_n, 8'hFF);
    check("t4_en_idx", dig_idx, 3'd1);
    en = 1'b1;
    wait_an(8'hFE, "t4_restart");
    digit_mask = '0;
    repeat (12) @(negedge clk);
    check("t4_mask_an", an_n, 8'hFF);
    check("t4_mask_seg", seg_n, 7'h7F);

    // Reset mid-ON of digit 4.
    digit_mask = 8'hFF;
    wait_an(8'hEF, "t5_d4");
    reset = 1'b1;
    @(negedge clk);
    check("t5_an", an_n, 8'hFF);
    check("t5_seg", seg_n, 7'h7F);
    check("t5_idx", dig_idx, 3'd0);
    reset = 1'b0;

    // Brightness window on a single digit.
    digit_mask = 8'h01;
    bright     = 4'd7;
    wait_an(8'hFF, "t6_gap");
    wait_an(8'hFE, "t6_b7");
    on_span(8'hFE, n_on, n_lit);
    check("t6_b7_on", n_on, ON);
`ifdef SCAN_PWM_EN
    check("t6_b7_lit", n_lit, 2);
`else
    check("t6_b7_lit", n_lit, ON);
`endif
    bright = 4'd0;
    wait_an(8'hFE, "t6_b0");
    on_span(8'hFE, n_on, n_lit);
    check("t6_b0_on", n_on, ON);
`ifdef SCAN_PWM_EN
    check("t6_b0_lit", n_lit, 0);
`else
    check("t6_b0_lit", n_lit, ON);
`endif

    // Random traffic, checked every cycle by the model.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      reset = ($urandom_range(0, 499) == 0);
      en    = ($urandom_range(0, 15) != 0);
      if ($urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 3))
          0: digit_mask = '0;
          1: digit_mask = N'(1) << $urandom_range(0, N - 1);
          default: digit_mask = N'($urandom);
        endcase
      end
      if ($urandom_range(0, 3) == 0) bcd_in = $urandom;
      bright = 4'($urandom);
    end
    @(negedge clk);
    chk_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
